// File: rtl/obi_mem_pkg.sv
// Shared types and widths for the OBI memory responder.
package obi_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {IDLE, WAIT} state_e;

endpackage

// File: rtl/obi_mem_ram.sv
// Word RAM with asynchronous read, byte-enabled bus write and whole-word backdoor write.
module obi_mem_ram
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o,
    input  logic              bus_we_i,
    input  logic [AW-1:0]     bus_idx_i,
    input  logic [BE_W-1:0]   bus_be_i,
    input  logic [WORD_W-1:0] bus_wdata_i,
    input  logic              bd_we_i,
    input  logic [AW-1:0]     bd_idx_i,
    input  logic [WORD_W-1:0] bd_wdata_i
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Backdoor is written first so the later bus byte writes override it on a collision.
    always_ff @(posedge clk_i) begin
        if (bd_we_i) begin
            mem[bd_idx_i] <= bd_wdata_i;
        end
        if (bus_we_i) begin
            for (int k = 0; k < int'(BE_W); k++) begin
                if (bus_be_i[k]) begin
                    mem[bus_idx_i][k*8 +: 8] <= bus_wdata_i[k*8 +: 8];
                end
            end
        end
    end

    assign rd_data_o = mem[rd_idx_i];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI data-side memory responder: stalled grant FSM, one-cycle response, store monitor port.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned GNT_STALL = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    input  logic              bd_we_i,
    input  logic [31:0]       bd_addr_i,
    input  logic [WORD_W-1:0] bd_wdata_i,
    output logic              st_valid_o,
    output logic [31:0]       st_addr_o,
    output logic [WORD_W-1:0] st_data_o,
    output logic [BE_W-1:0]   st_be_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              gnt;
    logic              rvalid_q;
    logic [WORD_W-1:0] rdata_q;
    logic              st_valid_q;
    logic [31:0]       st_addr_q;
    logic [WORD_W-1:0] st_data_q;
    logic [BE_W-1:0]   st_be_q;
    logic [WORD_W-1:0] ram_rdata;

    // Address bits outside the word index are deliberately ignored (wrap-around).
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0], bd_addr_i[31:AW+2], bd_addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (GNT_STALL == 0) begin
                        gnt = 1'b1;
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else if (cnt_q == 3'(GNT_STALL)) begin
                    gnt     = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_ni) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            st_valid_q <= 1'b0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            st_be_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= gnt;
            st_valid_q <= gnt & we_i;
            if (gnt) begin
                rdata_q <= we_i ? '0 : ram_rdata;
                if (we_i) begin
                    st_addr_q <= addr_i;
                    st_data_q <= wdata_i;
                    st_be_q   <= be_i;
                end
            end
        end
    end

    obi_mem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i       (clk_i),
        .rd_idx_i    (addr_i[AW+1:2]),
        .rd_data_o   (ram_rdata),
        .bus_we_i    (gnt & we_i),
        .bus_idx_i   (addr_i[AW+1:2]),
        .bus_be_i    (be_i),
        .bus_wdata_i (wdata_i),
        .bd_we_i     (bd_we_i),
        .bd_idx_i    (bd_addr_i[AW+1:2]),
        .bd_wdata_i  (bd_wdata_i)
    );

    // Outputs are forced low while reset is held so a response pending at reset never shows.
    assign gnt_o      = gnt;
    assign rvalid_o   = rvalid_q & rst_ni;
    assign rdata_o    = rst_ni ? rdata_q : '0;
    assign st_valid_o = st_valid_q & rst_ni;
    assign st_addr_o  = rst_ni ? st_addr_q : '0;
    assign st_data_o  = rst_ni ? st_data_q : '0;
    assign st_be_o    = rst_ni ? st_be_q : '0;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench: one responder with no grant stall, one with GNT_STALL=3, shared backdoor.
module tb_obi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we, bd_we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, bd_addr, bd_wdata;

    logic        gnt0, rvalid0, st_valid0;
    logic [31:0] rdata0, st_addr0, st_data0;
    logic [3:0]  st_be0;
    logic        gnt1, rvalid1, st_valid1;
    logic [31:0] rdata1, st_addr1, st_data1;
    logic [3:0]  st_be1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_mem_responder #(.DEPTH(256), .GNT_STALL(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .gnt_o(gnt0), .rvalid_o(rvalid0),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata0),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
        .st_valid_o(st_valid0), .st_addr_o(st_addr0), .st_data_o(st_data0), .st_be_o(st_be0)
    );

    obi_mem_responder #(.DEPTH(256), .GNT_STALL(3)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1),
        .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
        .st_valid_o(st_valid1), .st_addr_o(st_addr1), .st_data_o(st_data1), .st_be_o(st_be1)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        tick();
        tick();
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata0); end
        checks++;
        if ({st_valid0, st_addr0, st_data0, st_be0} !== '0) begin
            errors++; $display("FAIL reset_st: got %b/%h/%h/%h want all 0", st_valid0, st_addr0, st_data0, st_be0);
        end
        req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        bd_write(32'h10, 32'hDEADBEEF);
        req0 = 1'b1; we = 1'b0; addr = 32'h10;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL load_gnt: got %b want 1", gnt0); end
        tick();
        req0 = 1'b0;
        checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL load_rvalid: got %b want 1", rvalid0); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rdata0); end
        tick();
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL load_rvalid_pulse: got %b want 0", rvalid0); end
        checks++; if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata_hold: got %h want deadbeef", rdata0); end
    endtask

    task automatic test_store_then_load();
        bd_write(32'h20, 32'hFFFFFFFF);
        req0 = 1'b1; we = 1'b1; be = 4'b0101; addr = 32'h20; wdata = 32'h11223344;
        tick();
        // Load to the same word granted right after the store.
        we = 1'b0; be = 4'b0000; wdata = 32'h0;
        checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL store_rvalid: got %b want 1", rvalid0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rdata0); end
        checks++; if (st_valid0 !== 1'b1) begin errors++; $display("FAIL store_st_valid: got %b want 1", st_valid0); end
        checks++;
        if (st_addr0 !== 32'h20 || st_data0 !== 32'h11223344 || st_be0 !== 4'h5) begin
            errors++; $display("FAIL store_st_fields: got %h/%h/%h want 20/11223344/5", st_addr0, st_data0, st_be0);
        end
        tick();
        req0 = 1'b0;
        checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL b2b_rvalid: got %b want 1", rvalid0); end
        checks++; if (st_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_st_valid: got %b want 0", st_valid0); end
        checks++; if (rdata0 !== 32'hFF22FF44) begin errors++; $display("FAIL store_merge: got %h want ff22ff44", rdata0); end
        tick();
    endtask

    task automatic test_be_zero();
        req0 = 1'b1; we = 1'b1; be = 4'b0000; addr = 32'h20; wdata = 32'h0;
        tick();
        req0 = 1'b0; we = 1'b0;
        checks++;
        if (st_valid0 !== 1'b1 || rvalid0 !== 1'b1 || st_be0 !== 4'h0) begin
            errors++; $display("FAIL be0_resp: got st_valid=%b rvalid=%b be=%h want 1/1/0", st_valid0, rvalid0, st_be0);
        end
        req0 = 1'b1; addr = 32'h20;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'hFF22FF44) begin errors++; $display("FAIL be0_unchanged: got %h want ff22ff44", rdata0); end
        tick();
    endtask

    task automatic test_wrap();
        bd_write(32'h0, 32'hCAFEF00D);
        req0 = 1'b1; we = 1'b0; addr = 32'h400;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap: got %h want cafef00d", rdata0); end
        tick();
    endtask

    task automatic test_stall();
        req1 = 1'b1; we = 1'b0; addr = 32'h10;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (gnt1 !== (i == 4)) begin
                errors++; $display("FAIL stall_gnt_cycle%0d: got %b want %b", i, gnt1, (i == 4));
            end
            tick();
        end
        req1 = 1'b0;
        checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL stall_rvalid: got %b want 1", rvalid1); end
        checks++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_rdata: got %h want deadbeef", rdata1); end
        tick();
        begin
            logic seen = 1'b0;
            req1 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                #1; seen = seen | gnt1;
                tick(); seen = seen | rvalid1;
            end
            req1 = 1'b0;
            for (int i = 0; i < 5; i++) begin
                #1; seen = seen | gnt1;
                tick(); seen = seen | rvalid1;
            end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stall_abort: got activity=%b want 0", seen); end
        end
    endtask

    task automatic test_collision();
        bd_write(32'h30, 32'h0);
        req0 = 1'b1; we = 1'b1; be = 4'b0011; addr = 32'h30; wdata = 32'h11112222;
        bd_we = 1'b1; bd_addr = 32'h30; bd_wdata = 32'hAAAABBBB;
        tick();
        bd_we = 1'b0; we = 1'b0; be = 4'b0;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'hAAAA2222) begin errors++; $display("FAIL collision: got %h want aaaa2222", rdata0); end
        tick();
    endtask

    task automatic test_read_before_write();
        bd_write(32'h40, 32'h12345678);
        req0 = 1'b1; we = 1'b0; addr = 32'h40;
        bd_we = 1'b1; bd_addr = 32'h40; bd_wdata = 32'h9ABCDEF0;
        tick();
        bd_we = 1'b0;
        checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL rbw_old: got %h want 12345678", rdata0); end
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'h9ABCDEF0) begin errors++; $display("FAIL rbw_new: got %h want 9abcdef0", rdata0); end
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h50; wdata = 32'h0BADC0DE;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", gnt0); end
        tick();
        rst_n = 1'b0; req0 = 1'b0; we = 1'b0;
        #1;
        checks++;
        if ({rvalid0, st_valid0, gnt0} !== 3'b000 || rdata0 !== 32'h0 || {st_addr0, st_data0, st_be0} !== '0) begin
            errors++; $display("FAIL rmid_outputs: got rv=%b sv=%b g=%b rd=%h st=%h/%h/%h want all 0",
                               rvalid0, st_valid0, gnt0, rdata0, st_addr0, st_data0, st_be0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rmid_no_rvalid: got %b want 0", rvalid0); end
        req0 = 1'b1; addr = 32'h50;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'h0BADC0DE) begin errors++; $display("FAIL rmid_kept: got %h want 0badc0de", rdata0); end
        addr = 32'h20; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        checks++; if (rdata0 !== 32'hFF22FF44) begin errors++; $display("FAIL rmid_ram_kept: got %h want ff22ff44", rdata0); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; be = 4'h0;
        addr = 32'h0; wdata = 32'h0; bd_we = 1'b0; bd_addr = 32'h0; bd_wdata = 32'h0;
        test_reset();
        test_load();
        test_store_then_load();
        test_be_zero();
        test_wrap();
        test_stall();
        test_collision();
        test_read_before_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the internal RAM (power of two).
REQ-002 The block SHALL have parameter GNT_STALL, default 0, range 0..7, meaning the number of req cycles before gnt is given.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port req_i, input, 1 bit: core data request (driven by core data_req_o).
REQ-006 The block SHALL have port gnt_o, output, 1 bit: request accepted this cycle.
REQ-007 The block SHALL have port rvalid_o, output, 1 bit: response valid.
REQ-008 The block SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port be_i, input, 4 bits: byte enables.
REQ-010 The block SHALL have ports addr_i (input, 32 bits, byte address) and wdata_i (input, 32 bits, store data).
REQ-011 The block SHALL have port rdata_o, output, 32 bits: load data, valid with rvalid_o.
REQ-012 The block SHALL have ports bd_we_i (input, 1 bit), bd_addr_i (input, 32 bits) and bd_wdata_i (input, 32 bits): backdoor word write used by the bench to preload memory.
REQ-013 The block SHALL have ports st_valid_o (output, 1 bit), st_addr_o (output, 32 bits), st_data_o (output, 32 bits) and st_be_o (output, 4 bits): store capture reported to the monitor.

Function
REQ-014 Word index SHALL be addr_i[log2(DEPTH)+1:2]; addr_i[1:0] and upper bits are ignored, so out-of-range addresses wrap.
REQ-015 Grant FSM SHALL have states IDLE and WAIT with a 3-bit counter cnt.
- IDLE: req_i=1 and GNT_STALL=0 -> gnt_o=1 combinationally, stay IDLE.
- IDLE: req_i=1 and GNT_STALL>0 -> cnt=1, go WAIT.
- WAIT: gnt_o=1 when req_i=1 and cnt==GNT_STALL, then return to IDLE; otherwise cnt increments.
REQ-016 req_i dropping to 0 while in WAIT SHALL return the FSM to IDLE with no transaction and no response.
REQ-017 A granted transaction SHALL produce rvalid_o=1 for exactly one cycle, on the cycle after gnt_o; back-to-back grants SHALL give back-to-back rvalid pulses.
REQ-018 Load: rdata_o SHALL be the RAM word at grant time, registered, and held stable until the next rvalid.
REQ-019 Store: bytes with be_i[k]=1 SHALL be written at the grant edge; rdata_o during a store response SHALL be 0.
REQ-020 A store with be_i=0 SHALL leave memory unchanged but still respond and still pulse st_valid_o.
REQ-021 st_valid_o SHALL pulse coincident with rvalid_o of each store, with st_addr_o, st_data_o and st_be_o holding the granted values.
REQ-022 A load granted on the cycle after a store to the same word SHALL return the updated data.
REQ-023 When a bus store and bd_we_i target the same word in the same cycle, the bus store SHALL win for its enabled bytes and the backdoor SHALL write the other bytes.
REQ-024 When a load grant and bd_we_i hit the same word in the same cycle, the load SHALL return the old word (read-before-write).

Reset
REQ-025 While rst_ni=0 at a clock edge: FSM SHALL be IDLE; cnt, rvalid_o, st_valid_o, rdata_o and st_* SHALL be 0; gnt_o SHALL be 0 regardless of req_i.
REQ-026 Reset mid-transaction SHALL cancel any pending response, so no rvalid follows the reset.
REQ-027 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-028 Package obi_mem_pkg SHALL hold the FSM state enum (IDLE, WAIT), the word width constant 32 and the be width constant 4.
REQ-029 The RAM array SHALL be sub-module obi_mem_ram: 1 read port, 1 byte-enabled bus write port, 1 backdoor write port, with the priority of REQ-023.

Verification
REQ-030 Backdoor write 0x0000_0010 <- 0xDEADBEEF, GNT_STALL=0, load addr 0x10 -> gnt in the req cycle, rvalid next cycle, rdata 0xDEADBEEF.
REQ-031 Store addr 0x20, wdata 0x11223344, be 4'b0101 over 0xFFFFFFFF, then load 0x20 -> st_valid with be 0x5, load returns 0xFF22FF44.
REQ-032 GNT_STALL=3, req held -> gnt on 4th req cycle; req dropped after 2 cycles -> no gnt, no rvalid.
REQ-033 Load addr 0x400 with DEPTH=256 -> returns word 0 contents (wrap).
REQ-034 Assert rst_ni=0 on the cycle after a grant -> no rvalid, all outputs 0; previously stored data still readable afterwards.
REQ-035 Store and bd_we_i to the same word in the same cycle, be 4'b0011 -> low half from bus, high half from backdoor.
